// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary-to-binary decoder.
package unary_pkg;

  // Decoder frame state: waiting for a start strobe, or counting highs.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } udec_state_t;

  // Number of result slots between the decoder and its consumer.
  localparam int UDEC_FIFO_DEPTH = 2;

  // Width needed to hold every count from 0 up to and including u_bits.
  function automatic int cnt_width(input int u_bits);
    return $clog2(u_bits + 1);
  endfunction

endpackage

// File: rtl/unary_result_fifo.sv
// Small result buffer between the decoder and its consumer. Entry 0 is the
// head and is a plain register, so the consumer sees registered data/valid.
// Up to two values can arrive in one cycle (a frame ending plus a zero-length
// frame starting on the same cycle); they are stored in order, and any value
// that finds no free slot after this cycle's pop is silently discarded.
module unary_result_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             push_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Contents after the optional pop, before any push is placed.
  logic [DEPTH-1:0] shift_valid;
  logic [WIDTH-1:0] shift_data [DEPTH];

  logic pop_ok;
  logic placed_a;
  logic placed_b;

  // A pop is only meaningful when the head holds a value.
  assign pop_ok = pop & valid_q[0];

  // Popping moves every entry one slot toward the head; the tail is zeroed so
  // an empty head always reads as zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == DEPTH - 1) begin : g_tail
        assign shift_valid[gi] = pop_ok ? 1'b0 : valid_q[gi];
        assign shift_data[gi]  = pop_ok ? '0   : data_q[gi];
      end else begin : g_body
        assign shift_valid[gi] = pop_ok ? valid_q[gi+1] : valid_q[gi];
        assign shift_data[gi]  = pop_ok ? data_q[gi+1]  : data_q[gi];
      end
    end
  endgenerate

  // Place push_a then push_b into the first free slots; occupied slots are
  // contiguous from the head, so the first free slot is the next in order.
  always_comb begin
    valid_d  = shift_valid;
    placed_a = 1'b0;
    placed_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = shift_data[i];
    end
    if (push_a) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!placed_a && !valid_d[i]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = data_a;
          placed_a   = 1'b1;
        end
      end
    end
    if (push_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!placed_b && !valid_d[i]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = data_b;
          placed_b   = 1'b1;
        end
      end
    end
  end

  // Storage registers; reset empties the buffer and zeroes the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign head_data  = data_q[0];
  assign head_valid = valid_q[0];
  assign full       = &valid_q;
  assign empty      = ~valid_q[0];

endmodule

// File: rtl/unary_decoder.sv
// Converts a framed unary stream (N consecutive highs, first one flagged by
// start) back to a binary count and hands it to the consumer through a
// valid/ready interface backed by a two-entry result buffer.
module unary_decoder
  import unary_pkg::*;
#(
  parameter int  U_BITS = 16,
  localparam int CNT_W  = cnt_width(U_BITS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in,
  output logic [CNT_W-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_sat,
  output logic             err_drop,
  output logic             err_proto,
  input  logic             clear_err
);

  localparam logic [CNT_W-1:0] U_MAX = CNT_W'(U_BITS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  udec_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_sat_q, err_sat_d;
  logic             err_drop_q, err_drop_d;
  logic             err_proto_q, err_proto_d;

  // Completed results for this cycle; push_a is always the older of the two.
  logic             push_a, push_b;
  logic [CNT_W-1:0] data_a, data_b;
  logic             sat_evt, proto_evt, drop_evt;

  logic             pop;
  logic             fifo_full, fifo_empty;
  logic [1:0]       occ, n_push, room;

  // Frame FSM: decide next state/count and which results complete this cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    push_a    = 1'b0;
    data_a    = '0;
    push_b    = 1'b0;
    data_b    = '0;
    sat_evt   = 1'b0;
    proto_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Without start the stream is ignored.
        if (start) begin
          if (in) begin
            count_d = ONE;
            state_d = COUNT;
          end else begin
            push_a = 1'b1;
          end
        end
      end
      COUNT: begin
        if (!in) begin
          // Frame end. A start on this same cycle is a legal back-to-back
          // start; its first bit is low, so it is a zero-length frame.
          push_a  = 1'b1;
          data_a  = count_q;
          state_d = IDLE;
          count_d = '0;
          if (start) begin
            push_b = 1'b1;
          end
        end else if (start) begin
          // Start while the frame is still high: close out what was counted
          // so far and begin a new frame with this cycle's high.
          proto_evt = 1'b1;
          push_a    = 1'b1;
          data_a    = count_q;
          count_d   = ONE;
        end else if (count_q == U_MAX) begin
          sat_evt = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // A result is dropped when more values complete than there is room for
  // after this cycle's pop; the buffer keeps the older ones.
  always_comb begin
    occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    n_push   = {1'b0, push_a} + {1'b0, push_b};
    room     = 2'd2 - occ + {1'b0, pop};
    drop_evt = n_push > room;
  end

  // Sticky error flags: a new event wins over a coincident clear.
  always_comb begin
    err_sat_d   = (err_sat_q   & ~clear_err) | sat_evt;
    err_drop_d  = (err_drop_q  & ~clear_err) | drop_evt;
    err_proto_d = (err_proto_q & ~clear_err) | proto_evt;
  end

  // State, counter and error flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      err_sat_q   <= 1'b0;
      err_drop_q  <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_sat_q   <= err_sat_d;
      err_drop_q  <= err_drop_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign pop = out_valid & out_ready;

  unary_result_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (UDEC_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_a     (push_a),
    .data_a     (data_a),
    .push_b     (push_b),
    .data_b     (data_b),
    .pop        (pop),
    .head_data  (out_value),
    .head_valid (out_valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign busy      = (state_q == COUNT);
  assign err_sat   = err_sat_q;
  assign err_drop  = err_drop_q;
  assign err_proto = err_proto_q;

endmodule

// File: tb/tb_unary_decoder.sv
// Self-checking bench for unary_decoder: frame table, hand-written corner
// sequences and a random stream checked against a queue-based reference.
module tb_unary_decoder;
  import unary_pkg::*;

  localparam int U  = 16;
  localparam int CW = cnt_width(U);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_bit = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear_err = 1'b0;
  logic [CW-1:0] out_value;
  logic          out_valid;
  logic          busy;
  logic          err_sat;
  logic          err_drop;
  logic          err_proto;

  always #5 clk = ~clk;

  unary_decoder #(.U_BITS(U)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in        (in_bit),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err_sat   (err_sat),
    .err_drop  (err_drop),
    .err_proto (err_proto),
    .clear_err (clear_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: -1 when no frame is open, else highs seen so far (capped at U).
  int m_run = -1;
  int m_q[$];
  bit m_sat, m_drop, m_proto;

  typedef struct {
    int n;
    int exp_value;
    bit exp_sat;
  } frame_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = -1;
    m_q.delete();
    m_sat = 0;
    m_drop = 0;
    m_proto = 0;
  endfunction

  // One clock of the frame rules, written from the stream's point of view.
  function automatic void model_step(input bit s, input bit i, input bit rdy, input bit clr);
    int done[$];
    bit sat_e = 0, proto_e = 0, drop_e = 0;
    if (m_run >= 0) begin
      if (!i) begin
        done.push_back(m_run);
        m_run = -1;
      end else if (s) begin
        proto_e = 1;
        done.push_back(m_run);
        m_run = -1;
      end else if (m_run == U) begin
        sat_e = 1;
      end else begin
        m_run++;
      end
    end
    if (m_run < 0 && s) begin
      if (i) m_run = 1;
      else done.push_back(0);
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    foreach (done[k]) begin
      if (m_q.size() < 2) m_q.push_back(done[k]);
      else drop_e = 1;
    end
    m_sat   = (m_sat   & ~clr) | sat_e;
    m_drop  = (m_drop  & ~clr) | drop_e;
    m_proto = (m_proto & ~clr) | proto_e;
  endfunction

  task automatic check_model();
    chk("valid", out_valid, m_q.size() > 0);
    chk("value", out_value, (m_q.size() > 0) ? m_q[0] : 0);
    chk("busy", busy, m_run >= 0);
    chk("err_sat", err_sat, m_sat);
    chk("err_drop", err_drop, m_drop);
    chk("err_proto", err_proto, m_proto);
  endtask

  // Drive one cycle of inputs, advance reference, compare just after the edge.
  task automatic cycle(input bit s, input bit i, input bit rdy, input bit clr);
    start = s;
    in_bit = i;
    out_ready = rdy;
    clear_err = clr;
    @(posedge clk);
    model_step(s, i, rdy, clr);
    #1;
    check_model();
  endtask

  // Drive a clean frame of n highs followed by one low (n=0: start with in low).
  task automatic frame(input int n, input bit rdy);
    if (n == 0) begin
      cycle(1, 0, rdy, 0);
    end else begin
      cycle(1, 1, rdy, 0);
      for (int k = 1; k < n; k++) cycle(0, 1, rdy, 0);
      cycle(0, 0, rdy, 0);
    end
  endtask

  frame_vec_t vecs[6];

  initial begin
    vecs[0] = '{n: 5,  exp_value: 5,  exp_sat: 0};
    vecs[1] = '{n: 0,  exp_value: 0,  exp_sat: 0};
    vecs[2] = '{n: 1,  exp_value: 1,  exp_sat: 0};
    vecs[3] = '{n: 16, exp_value: 16, exp_sat: 0};
    vecs[4] = '{n: 17, exp_value: 16, exp_sat: 1};
    vecs[5] = '{n: 20, exp_value: 16, exp_sat: 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_value", out_value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_sat, err_drop, err_proto}, 0);
    reset_n = 1'b1;
    cycle(0, 1, 1, 0);

    // Frame table, consumer always ready
    foreach (vecs[v]) begin
      frame(vecs[v].n, 1);
      $display("frame n=%0d -> value %0d valid %0b sat %0b", vecs[v].n, out_value, out_valid, err_sat);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_value", out_value, vecs[v].exp_value);
      chk("tbl_sat", err_sat, vecs[v].exp_sat);
      cycle(0, 0, 1, 0);
      chk("tbl_one_cycle", out_valid, 0);
      cycle(0, 0, 1, 1);
      chk("tbl_clear_sat", err_sat, 0);
    end

    // Stalled consumer: 3 and 7 kept, 2 dropped
    frame(3, 0);
    frame(7, 0);
    frame(2, 0);
    chk("stall_head", out_value, 3);
    chk("stall_drop", err_drop, 1);
    cycle(0, 0, 1, 0);
    chk("stall_second", out_value, 7);
    cycle(0, 0, 1, 0);
    chk("stall_empty", out_valid, 0);
    $display("stall sequence: drained, err_drop %0b", err_drop);
    cycle(0, 0, 1, 1);

    // Start while still high after 4 highs, then 2 more
    cycle(1, 1, 1, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 0);
    chk("proto_flag", err_proto, 1);
    chk("proto_first", out_value, 4);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    chk("proto_second", out_value, 2);
    $display("proto sequence: second value %0d", out_value);
    cycle(0, 0, 1, 1);

    // Back-to-back: start on the frame's falling cycle is not a protocol error
    cycle(1, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(1, 0, 1, 0);
    chk("b2b_first", out_value, 2);
    chk("b2b_no_proto", err_proto, 0);
    cycle(0, 0, 1, 0);
    chk("b2b_zero_valid", out_valid, 1);
    chk("b2b_zero_value", out_value, 0);
    cycle(0, 0, 1, 0);

    // Async reset mid-frame with one result buffered
    frame(3, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    frame(2, 1);
    chk("arst_next", out_value, 2);
    $display("async reset sequence: next frame value %0d", out_value);
    cycle(0, 0, 1, 0);

    // Random stream against the reference
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom % 8) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, ($urandom % 32) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
